// File: rtl/cc_fill_arbiter_if.sv
// cc_fill_arbiter_if: request, response-FIFO and serializer-monitor signals of the fill arbiter
interface cc_fill_arbiter_if;
  logic         hit_valid_i;
  logic [5:0]   hit_offset_i;
  logic [511:0] hit_data_i;
  logic         hit_ready_o;
  logic         mem_valid_i;
  logic [5:0]   mem_offset_i;
  logic [511:0] mem_data_i;
  logic         mem_ready_o;
  logic         fifo_full_i;
  logic         fifo_afull_i;
  logic         fifo_wren_o;
  logic [517:0] fifo_wdata_o;
  logic         rvalid_i;
  logic         rready_i;
  logic         rlast_i;
  logic [2:0]   outstanding_o;
  logic         err_o;
  modport master (
    output hit_valid_i, hit_offset_i, hit_data_i, mem_valid_i, mem_offset_i, mem_data_i,
    output fifo_full_i, fifo_afull_i, rvalid_i, rready_i, rlast_i,
    input  hit_ready_o, mem_ready_o, fifo_wren_o, fifo_wdata_o, outstanding_o, err_o
  );
  modport slave (
    input  hit_valid_i, hit_offset_i, hit_data_i, mem_valid_i, mem_offset_i, mem_data_i,
    input  fifo_full_i, fifo_afull_i, rvalid_i, rready_i, rlast_i,
    output hit_ready_o, mem_ready_o, fifo_wren_o, fifo_wdata_o, outstanding_o, err_o
  );
endinterface

// File: rtl/cc_fill_arbiter.sv
// cc_fill_arbiter: round-robin hit/fill line arbiter feeding the response FIFO with credit tracking
module cc_fill_arbiter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input logic clk,
  input logic rst,
  cc_fill_arbiter_if.slave bus
);
  localparam logic [2:0] MAX = 3'(MAX_OUTSTANDING);
  logic         r_wren;
  logic [517:0] r_wdata;
  logic [2:0]   r_out;
  logic         r_err;
  logic         r_last_mem;
  logic         w_allow;
  logic         w_gnt_hit;
  logic         w_gnt_mem;
  logic         w_acc;
  logic         w_dec;
  // accept gating and round-robin grant; a tie goes to whichever source was not granted last
  always_comb begin
    w_allow   = !rst && !bus.fifo_full_i && !bus.fifo_afull_i && !r_wren && (r_out < MAX);
    w_gnt_hit = w_allow && bus.hit_valid_i && (!bus.mem_valid_i || r_last_mem);
    w_gnt_mem = w_allow && bus.mem_valid_i && (!bus.hit_valid_i || !r_last_mem);
    w_acc     = w_gnt_hit || w_gnt_mem;
    w_dec     = bus.rvalid_i && bus.rready_i && bus.rlast_i;
  end
  assign bus.hit_ready_o   = w_gnt_hit;
  assign bus.mem_ready_o   = w_gnt_mem;
  assign bus.fifo_wren_o   = r_wren;
  assign bus.fifo_wdata_o  = r_wdata;
  assign bus.outstanding_o = r_out;
  assign bus.err_o         = r_err;
  // FIFO write pulse, winner capture, in-flight credit count and sticky protocol error
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wren     <= 1'b0;
      r_wdata    <= '0;
      r_out      <= 3'd0;
      r_err      <= 1'b0;
      r_last_mem <= 1'b0;
    end else begin
      r_wren <= w_acc;
      if (w_acc) begin
        r_wdata    <= w_gnt_hit ? {bus.hit_offset_i, bus.hit_data_i} : {bus.mem_offset_i, bus.mem_data_i};
        r_last_mem <= w_gnt_mem;
      end
      if (w_acc && !w_dec) r_out <= r_out + 3'd1;
      else if (w_dec && !w_acc && r_out != 3'd0) r_out <= r_out - 3'd1;
      if ((w_dec && !w_acc && r_out == 3'd0) || (r_wren && bus.fifo_full_i)) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cc_fill_arbiter.sv
// tb_cc_fill_arbiter: vector table, directed corner cases and random traffic against a reference model
module tb_cc_fill_arbiter;
  localparam int MAX = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cc_fill_arbiter_if bus();
  cc_fill_arbiter #(.MAX_OUTSTANDING(MAX)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int           m_cnt = 0;
  logic         m_err = 1'b0;
  logic         m_last_mem = 1'b0;
  logic         m_wren = 1'b0;
  logic [517:0] m_wdata = '0;
  logic         s_hr, s_mr;
  logic [511:0] pat_a, pat_b;

  typedef struct {
    logic hv, mv, afull, dec;
    logic hr, mr, wren;
    int   out;
  } vec_t;
  vec_t tbl[18];

  task automatic chk(input string name, input logic [517:0] act, input logic [517:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic hv, input logic [5:0] ho, input logic [511:0] hd,
                      input logic mv, input logic [5:0] mo, input logic [511:0] md,
                      input logic full, input logic afull, input logic rv, input logic rr, input logic rl);
    logic allow, eh, em, dec;
    @(negedge clk);
    rst = r;
    bus.hit_valid_i = hv; bus.hit_offset_i = ho; bus.hit_data_i = hd;
    bus.mem_valid_i = mv; bus.mem_offset_i = mo; bus.mem_data_i = md;
    bus.fifo_full_i = full; bus.fifo_afull_i = afull;
    bus.rvalid_i = rv; bus.rready_i = rr; bus.rlast_i = rl;
    #1;
    allow = !r && !full && !afull && !m_wren && (m_cnt < MAX);
    eh = 1'b0; em = 1'b0;
    if (allow) begin
      if (hv && mv) begin
        em = !m_last_mem;
        eh = m_last_mem;
      end else begin
        eh = hv;
        em = mv;
      end
    end
    s_hr = bus.hit_ready_o;
    s_mr = bus.mem_ready_o;
    chk("hit_ready", 518'(s_hr), 518'(eh));
    chk("mem_ready", 518'(s_mr), 518'(em));
    dec = rv && rr && rl;
    @(posedge clk);
    if (r) begin
      m_cnt = 0; m_err = 1'b0; m_last_mem = 1'b0; m_wren = 1'b0; m_wdata = '0;
    end else begin
      if (m_wren && full) m_err = 1'b1;
      if (dec && !(eh || em) && m_cnt == 0) m_err = 1'b1;
      else m_cnt = m_cnt + int'(eh || em) - int'(dec);
      m_wren = eh || em;
      if (eh) m_wdata = {ho, hd};
      if (em) m_wdata = {mo, md};
      if (eh || em) m_last_mem = em;
    end
    #1;
    chk("wren", 518'(bus.fifo_wren_o), 518'(m_wren));
    chk("wdata", bus.fifo_wdata_o, m_wdata);
    chk("outstanding", 518'(bus.outstanding_o), 518'(m_cnt));
    chk("err", 518'(bus.err_o), 518'(m_err));
  endtask

  task automatic idle(input logic r);
    step(r, 1'b0, 6'h0, '0, 1'b0, 6'h0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic hv, mv, rl;
    logic [5:0] ho, mo;
    logic [511:0] hd, md;
    bus.hit_valid_i = 0; bus.hit_offset_i = 0; bus.hit_data_i = '0;
    bus.mem_valid_i = 0; bus.mem_offset_i = 0; bus.mem_data_i = '0;
    bus.fifo_full_i = 0; bus.fifo_afull_i = 0;
    bus.rvalid_i = 0; bus.rready_i = 0; bus.rlast_i = 0;
    pat_a = {16{32'hA5A5_0001}};
    pat_b = {16{32'h5A5A_0002}};
    //             hv mv af dec hr mr wr out
    tbl[0]  = '{1, 1, 0, 0, 0, 1, 1, 1};
    tbl[1]  = '{1, 1, 0, 0, 0, 0, 0, 1};
    tbl[2]  = '{1, 1, 0, 0, 1, 0, 1, 2};
    tbl[3]  = '{1, 1, 0, 0, 0, 0, 0, 2};
    tbl[4]  = '{1, 1, 0, 0, 0, 1, 1, 3};
    tbl[5]  = '{1, 1, 0, 0, 0, 0, 0, 3};
    tbl[6]  = '{1, 1, 0, 0, 1, 0, 1, 4};
    tbl[7]  = '{1, 1, 0, 0, 0, 0, 0, 4};
    tbl[8]  = '{1, 1, 0, 0, 0, 0, 0, 4};
    tbl[9]  = '{1, 1, 0, 1, 0, 0, 0, 3};
    tbl[10] = '{1, 1, 0, 0, 0, 1, 1, 4};
    tbl[11] = '{1, 0, 0, 1, 0, 0, 0, 3};
    tbl[12] = '{1, 1, 0, 1, 1, 0, 1, 3};
    tbl[13] = '{0, 1, 0, 1, 0, 0, 0, 2};
    tbl[14] = '{1, 1, 1, 0, 0, 0, 0, 2};
    tbl[15] = '{1, 1, 0, 0, 0, 1, 1, 3};
    tbl[16] = '{1, 0, 0, 1, 0, 0, 0, 2};
    tbl[17] = '{1, 1, 0, 1, 1, 0, 1, 2};

    idle(1'b1);
    idle(1'b1);
    chk("reset_wren", 518'(bus.fifo_wren_o), 518'(0));
    chk("reset_wdata", bus.fifo_wdata_o, '0);
    chk("reset_out", 518'(bus.outstanding_o), 518'(0));
    chk("reset_err", 518'(bus.err_o), 518'(0));

    for (int i = 0; i < 18; i++) begin
      step(1'b0, tbl[i].hv, 6'h18, pat_a, tbl[i].mv, 6'h05, pat_b,
           1'b0, tbl[i].afull, tbl[i].dec, tbl[i].dec, tbl[i].dec);
      chk($sformatf("tbl%0d_hr", i), 518'(s_hr), 518'(tbl[i].hr));
      chk($sformatf("tbl%0d_mr", i), 518'(s_mr), 518'(tbl[i].mr));
      chk($sformatf("tbl%0d_wren", i), 518'(bus.fifo_wren_o), 518'(tbl[i].wren));
      chk($sformatf("tbl%0d_out", i), 518'(bus.outstanding_o), 518'(tbl[i].out));
    end

    idle(1'b1);
    step(1'b0, 1'b1, 6'h18, pat_a, 1'b0, 6'h0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("single_hr", 518'(s_hr), 518'(1));
    chk("single_wren", 518'(bus.fifo_wren_o), 518'(1));
    chk("single_wdata", bus.fifo_wdata_o, {6'h18, pat_a});
    chk("single_out", 518'(bus.outstanding_o), 518'(1));

    idle(1'b1);
    step(1'b0, 1'b0, 6'h0, '0, 1'b0, 6'h0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("underflow_err", 518'(bus.err_o), 518'(1));
    chk("underflow_out", 518'(bus.outstanding_o), 518'(0));
    idle(1'b0);
    chk("err_sticky", 518'(bus.err_o), 518'(1));
    step(1'b0, 1'b0, 6'h0, '0, 1'b1, 6'h21, pat_b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pend_wren", 518'(bus.fifo_wren_o), 518'(1));
    step(1'b1, 1'b1, 6'h18, pat_a, 1'b1, 6'h21, pat_b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_hr", 518'(s_hr), 518'(0));
    chk("rst_mr", 518'(s_mr), 518'(0));
    chk("rst_wren", 518'(bus.fifo_wren_o), 518'(0));
    chk("rst_out", 518'(bus.outstanding_o), 518'(0));
    chk("rst_err", 518'(bus.err_o), 518'(0));
    step(1'b0, 1'b1, 6'h18, pat_a, 1'b1, 6'h21, pat_b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_tie_mem", 518'(s_mr), 518'(1));

    idle(1'b1);
    step(1'b0, 1'b1, 6'h18, pat_a, 1'b0, 6'h0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 6'h0, '0, 1'b0, 6'h0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_wren_err", 518'(bus.err_o), 518'(1));

    idle(1'b1);
    hv = 0; mv = 0; ho = '0; mo = '0; hd = '0; md = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!hv && $urandom_range(0, 1) == 0) begin
        hv = 1'b1;
        ho = 6'($urandom);
        for (int k = 0; k < 16; k++) hd[k*32 +: 32] = $urandom;
      end
      if (!mv && $urandom_range(0, 1) == 0) begin
        mv = 1'b1;
        mo = 6'($urandom);
        for (int k = 0; k < 16; k++) md[k*32 +: 32] = $urandom;
      end
      rl = ($urandom_range(0, 3) == 0) && (m_cnt > 0);
      step(1'b0, hv, ho, hd, mv, mo, md,
           $urandom_range(0, 40) == 0, $urandom_range(0, 7) == 0,
           1'($urandom), 1'($urandom), rl);
      if (s_hr) hv = 1'b0;
      if (s_mr) mv = 1'b0;
      if (n % 500 == 499) idle(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
